// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit scheduler: state encoding and
// the default word width used by udp_tx_path.
package udp_pkg;

    localparam int UDP_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/udp_tx_sched_if.sv
// Source-side word streams plus the single din_* stream into udp_tx_path.
// master = scheduler side, slave = producers / udp_tx_path side.
interface udp_tx_sched_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 64
);
    logic [NUM_SRC*DATA_W-1:0] s_data;
    logic [NUM_SRC-1:0]        s_valid;
    logic [NUM_SRC-1:0]        s_last;
    logic [NUM_SRC-1:0]        s_ready;
    logic [DATA_W-1:0]         din_data;
    logic                      din_valid;
    logic                      din_last;
    logic                      din_ready;

    modport master (
        input  s_data, s_valid, s_last, din_ready,
        output s_ready, din_data, din_valid, din_last
    );

    modport slave (
        output s_data, s_valid, s_last, din_ready,
        input  s_ready, din_data, din_valid, din_last
    );
endinterface

// File: rtl/udp_tx_sched_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last,
    output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_SRC);

    // Scan last+1 .. last+NUM_SRC (mod NUM_SRC); the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/udp_tx_sched.sv
// Packet scheduler feeding udp_tx_path: round-robin across sources with the
// grant held for a whole packet, per-source packet-rate limit per period, and
// forced termination of packets longer than MAX_WORDS.
module udp_tx_sched
    import udp_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = UDP_DATA_W,
    parameter int MAX_WORDS  = 256,
    parameter int PERIOD_CYC = 125_000_000,
    parameter int RATE_W     = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    udp_tx_sched_if.master             bus,
    input  logic [RATE_W-1:0]          cfg_rate,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       trunc_err
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int WC_W  = $clog2(MAX_WORDS + 1);
    localparam int PC_W  = $clog2(PERIOD_CYC + 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   grant, last_grant, pick_idx;
    logic               pick_any;
    logic [WC_W-1:0]    word_cnt;
    logic [PC_W-1:0]    period_cnt;
    logic [RATE_W-1:0]  used [NUM_SRC];
    logic [NUM_SRC-1:0] elig;
    logic [DATA_W-1:0]  src_data;
    logic               src_valid, src_last;
    logic               acc, trunc, take_grant, period_wrap;

    assign src_data    = bus.s_data[int'(grant)*DATA_W +: DATA_W];
    assign src_valid   = bus.s_valid[grant];
    assign src_last    = bus.s_last[grant];
    assign period_wrap = (period_cnt == PC_W'(PERIOD_CYC - 1));
    assign grant_id    = grant;
    assign busy        = (state != ST_IDLE);

    // A requester is eligible while it still has packets left in this period.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SRC; i++)
            elig[i] = bus.s_valid[i] && ((cfg_rate == '0) || (used[i] < cfg_rate));
    end

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req     (elig),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Next state and the combinational pass-through / drain outputs.
    always_comb begin
        state_nxt     = state;
        bus.s_ready   = '0;
        bus.din_data  = '0;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
        acc           = 1'b0;
        trunc         = 1'b0;
        take_grant    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    take_grant = 1'b1;
                    state_nxt  = ST_PASS;
                end
            end
            ST_PASS: begin
                bus.din_data         = src_data;
                bus.din_valid        = src_valid;
                bus.s_ready[grant]   = bus.din_ready;
                acc                  = src_valid && bus.din_ready;
                // The MAX_WORDS-th accepted word closes the packet downstream
                // even if the source has more to say.
                trunc                = acc && !src_last && (word_cnt == WC_W'(MAX_WORDS - 1));
                bus.din_last         = src_last || trunc;
                if (acc && src_last)
                    state_nxt = ST_IDLE;
                else if (trunc)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Swallow the rest of the oversize packet without forwarding it.
                bus.s_ready[grant] = 1'b1;
                if (src_valid && src_last)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, grant bookkeeping, word count and the registered truncation pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
            word_cnt   <= '0;
            trunc_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            trunc_err <= trunc;
            if (take_grant) begin
                grant    <= pick_idx;
                word_cnt <= '0;
            end else if (acc) begin
                word_cnt <= word_cnt + WC_W'(1);
            end
            if (state != ST_IDLE && state_nxt == ST_IDLE)
                last_grant <= grant;
        end
    end

    // Rate period: on wrap every budget restarts, a same-cycle grant counts as 1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            period_cnt <= '0;
            for (int i = 0; i < NUM_SRC; i++) used[i] <= '0;
        end else begin
            period_cnt <= period_wrap ? '0 : period_cnt + PC_W'(1);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (period_wrap)
                    used[i] <= (take_grant && pick_idx == IDX_W'(i)) ? RATE_W'(1) : '0;
                else if (take_grant && pick_idx == IDX_W'(i) && used[i] != '1)
                    used[i] <= used[i] + RATE_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: table-driven packet sequences plus
// hand-written fairness, rate-limit, backpressure and reset sequences.
module tb_udp_tx_sched;
    localparam int NS = 4;
    localparam int DW = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] cfg_rate;
    logic [1:0] grant_id;
    logic       busy, trunc_err;

    udp_tx_sched_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

    udp_tx_sched #(
        .NUM_SRC(NS), .DATA_W(DW), .MAX_WORDS(4), .PERIOD_CYC(100), .RATE_W(8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.master),
        .cfg_rate  (cfg_rate),
        .grant_id  (grant_id),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] sv, sl;
        logic       rdy;
        logic [1:0] gid;
        logic       bsy, dv, dl;
        logic [3:0] srdy;
        logic       trn, pass;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [3:0] sv, input logic [3:0] sl, input logic rdy,
                                input logic [1:0] gid, input logic bsy, input logic dv,
                                input logic dl, input logic [3:0] srdy, input logic trn,
                                input logic pass);
        vec_t v;
        v.sv = sv; v.sl = sl; v.rdy = rdy; v.gid = gid; v.bsy = bsy;
        v.dv = dv; v.dl = dl; v.srdy = srdy; v.trn = trn; v.pass = pass;
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int g, input int k);
        return DW'(4096 * (g + 1) + k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_data(input int k);
        for (int i = 0; i < NS; i++) bus.s_data[i*DW +: DW] = exp_word(i, k);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n     = 1'b0;
        bus.s_valid   = '0;
        bus.s_last    = '0;
        bus.din_ready = 1'b1;
        cfg_rate      = '0;
        set_data(0);
        step();
        step();
        sys_rst_n = 1'b1;
    endtask

    task automatic chk_rst(input string tag);
        check({tag, "_dvalid"}, 32'(bus.din_valid), 0);
        check({tag, "_dlast"},  32'(bus.din_last), 0);
        check({tag, "_ddata"},  32'(bus.din_data), 0);
        check({tag, "_sready"}, 32'(bus.s_ready), 0);
        check({tag, "_gid"},    32'(grant_id), 0);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_trunc"},  32'(trunc_err), 0);
    endtask

    task automatic run_table(input int a, input int b);
        vec_t v;
        logic [31:0] act, exp;
        for (int k = a; k < b; k++) begin
            v = tbl[k];
            bus.s_valid   = v.sv;
            bus.s_last    = v.sl;
            bus.din_ready = v.rdy;
            set_data(k);
            #2;
            exp = {6'd0, v.gid, v.bsy, v.dv, v.dl, v.srdy, v.trn,
                   (v.pass ? exp_word(int'(v.gid), k) : DW'(0))};
            act = {6'd0, grant_id, busy, bus.din_valid, bus.din_last, bus.s_ready, trunc_err,
                   bus.din_data};
            check($sformatf("vec%0d", k), act, exp);
            step();
        end
    endtask

    initial begin
        int w;
        // Interleaved sources 0 and 2, two words each (k 0..6).
        tbl.push_back(mk(4'b0101, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0101, 4'b0000, 1, 0, 1, 1, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0101, 4'b0001, 1, 0, 1, 1, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0100, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0000, 1, 2, 1, 1, 0, 4'b0100, 0, 1));
        tbl.push_back(mk(4'b0100, 4'b0100, 1, 2, 1, 1, 1, 4'b0100, 0, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 2, 0, 0, 0, 4'b0000, 0, 0));
        // Source 3 runs 6 words with MAX_WORDS=4, then source 0 ends exactly on word 4 (k 7..19).
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 3, 1, 1, 0, 4'b1000, 0, 1));
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 3, 1, 1, 0, 4'b1000, 0, 1));
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 3, 1, 1, 0, 4'b1000, 0, 1));
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 3, 1, 1, 1, 4'b1000, 0, 1));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 3, 1, 0, 0, 4'b1000, 1, 0));
        tbl.push_back(mk(4'b1000, 4'b1000, 1, 3, 1, 0, 0, 4'b1000, 0, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, 1, 3, 0, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, 1, 0, 1, 1, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0001, 4'b0000, 1, 0, 1, 1, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0001, 4'b0000, 1, 0, 1, 1, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0001, 4'b0001, 1, 0, 1, 1, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0, 0));

        // Reset values while held in reset.
        bus.s_valid = '0; bus.s_last = '0; bus.din_ready = 1'b1; cfg_rate = '0; set_data(0);
        #1;
        chk_rst("por");

        do_reset();
        run_table(0, 7);
        do_reset();
        run_table(7, 20);

        // Backpressure on a 3-word packet from source 1.
        bus.s_valid = 4'b0010; bus.s_last = '0; bus.din_ready = 1'b1;
        #2;
        check("bp_idle_busy", 32'(busy), 0);
        step();
        w = 0;
        for (int cyc = 0; cyc < 40 && w < 3; cyc++) begin
            bus.din_ready = (cyc == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            bus.s_last    = (w == 2) ? 4'b0010 : 4'b0000;
            bus.s_data[DW +: DW] = DW'(16'h5000 + w);
            #2;
            check("bp_sready", 32'(bus.s_ready), 32'({2'b00, bus.din_ready, 1'b0}));
            check("bp_data",   32'(bus.din_data), 32'(16'h5000 + w));
            check("bp_dvalid", 32'(bus.din_valid), 1);
            check("bp_dlast",  32'(bus.din_last), (w == 2) ? 1 : 0);
            if (bus.din_ready) w++;
            step();
        end
        bus.s_valid = '0; bus.din_ready = 1'b1;
        #2;
        check("bp_words", 32'(w), 3);
        check("bp_done_busy", 32'(busy), 0);

        // Fairness: everyone asks continuously with 1-word packets.
        do_reset();
        bus.s_valid = 4'b1111; bus.s_last = 4'b1111;
        for (int p = 0; p < 8; p++) begin
            #2;
            check("fair_idle", 32'(busy), 0);
            step();
            #2;
            check("fair_gid",    32'(grant_id), 32'(p % 4));
            check("fair_sready", 32'(bus.s_ready), 32'(1 << (p % 4)));
            check("fair_data",   32'(bus.din_data), 32'(exp_word(p % 4, 0)));
            step();
        end

        // Rate limit 2 per 100 cycles, source 1 always asking.
        do_reset();
        cfg_rate = 8'd2; bus.s_valid = 4'b0010; bus.s_last = 4'b0010;
        for (int c = 0; c < 205; c++) begin
            #2;
            check($sformatf("rate_busy_c%0d", c), 32'(busy), (c % 100 == 1 || c % 100 == 3) ? 1 : 0);
            step();
        end

        // Grant landing on the wrap cycle is charged to the new period.
        do_reset();
        cfg_rate = 8'd2; bus.s_last = 4'b0010;
        for (int c = 0; c < 110; c++) begin
            bus.s_valid = (c >= 99) ? 4'b0010 : 4'b0000;
            #2;
            if (c >= 98)
                check($sformatf("wrap_busy_c%0d", c), 32'(busy), (c == 100 || c == 102) ? 1 : 0);
            step();
        end

        // Reset mid-packet, then source 0 must win first.
        do_reset();
        set_data(7);
        bus.s_valid = 4'b0100; bus.s_last = '0;
        step();
        #2;
        check("mid_gid",  32'(grant_id), 2);
        check("mid_busy", 32'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk_rst("mid_rst");
        bus.s_valid = 4'b0101;
        step();
        sys_rst_n = 1'b1;
        #2;
        check("post_rst_idle", 32'(busy), 0);
        step();
        #2;
        check("post_rst_gid",  32'(grant_id), 0);
        check("post_rst_busy", 32'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/udp_tx_sched.md
# udp_tx_sched

Packet-level scheduler in the `sys_clk` domain that shares the single `udp_tx_path` application input (`din_*`) among `NUM_SRC` word-stream producers, for example ADC framers. It performs round-robin arbitration with whole-packet grant locking. It also applies a per-source packet-rate limit over a fixed period and enforces a maximum packet length so that a runaway source cannot stall the UDP transmit path.

## Interface
Parameters:
- `NUM_SRC`, 4, number of requesters (2..8).
- `DATA_W`, 64, word width; must match `udp_tx_path`.
- `MAX_WORDS`, 256, maximum words per packet before forced termination.
- `PERIOD_CYC`, 125_000_000, rate-limit period in `sys_clk` cycles.
- `RATE_W`, 16, width of the rate limit and the per-source packet counters.

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `s_data` in `NUM_SRC*DATA_W`: source words; source i occupies bits `[i*DATA_W +: DATA_W]`.
- `s_valid` in `NUM_SRC`: source word valid.
- `s_last` in `NUM_SRC`: last word of the packet.
- `s_ready` out `NUM_SRC`: source word accepted.
- `din_data` out `DATA_W`: word to `udp_tx_path`.
- `din_valid` out 1: word valid to `udp_tx_path`.
- `din_last` out 1: end of packet to `udp_tx_path`.
- `din_ready` in 1: backpressure from `udp_tx_path`.
- `cfg_rate` in `RATE_W`: maximum packets per source per period; 0 means unlimited. Sampled every cycle.
- `grant_id` out `$clog2(NUM_SRC)`: currently or last granted source.
- `busy` out 1: high in PASS or DRAIN.
- `trunc_err` out 1: one-cycle pulse when a packet is force-terminated.

## Operation
States are IDLE, PASS and DRAIN.

IDLE:
- `s_ready`, `din_valid` and `din_last` are 0.
- A source is eligible when `s_valid[i]` is high and either `cfg_rate` is 0 or `used[i] < cfg_rate`.
- If any source is eligible, the block picks the first eligible index searching from `last_grant+1` with modulo wrap. It registers `grant_id`, increments `used[grant]` (saturating), and moves to PASS.

PASS:
- Combinational pass-through of the granted source: `din_data = s_data[grant]`, `din_valid = s_valid[grant]`, `s_ready[grant] = din_ready`. All other `s_ready` bits are 0.
- `word_cnt` counts each accepted word (`din_valid & din_ready`).
- On an accepted word with `s_last[grant]` high: `last_grant <= grant`, then go to IDLE.
- When the accepted word is number `MAX_WORDS` (`word_cnt == MAX_WORDS-1`) and `s_last` is low:
  - force `din_last` high combinationally on that word;
  - pulse `trunc_err`;
  - go to DRAIN.
- Otherwise `din_last = s_last[grant]`.

DRAIN:
- `s_ready[grant]` is 1 and `din_valid` is 0; the remaining words of the granted source are discarded.
- On `s_valid & s_last` from the granted source: `last_grant <= grant`, then go to IDLE.

Rate period:
- `period_cnt` counts 0..`PERIOD_CYC-1` and wraps.
- On wrap, all `used[i]` clear to 0.
- If a wrap and a grant occur in the same cycle, the granted source's `used` is set to 1 (the new period counts it).

Reset:
- Outputs: `din_valid`=0, `din_last`=0, `din_data`=0, `s_ready`=0, `grant_id`=0, `busy`=0, `trunc_err`=0.
- Internal: state IDLE, `last_grant = NUM_SRC-1` (so source 0 wins first), counters 0.
- Reset asserted mid-packet aborts the packet immediately. `udp_tx_path` is reset with it.

`din_data` is 0 whenever the state is not PASS.

## Timing
- Arbitration costs exactly one IDLE cycle per packet: a request seen in IDLE at cycle n gives the first word presentable at cycle n+1.
- From PASS back to PASS with another source requesting takes at least one cycle (the IDLE cycle). Packet throughput is therefore L words in L+1 cycles with no backpressure.
- Data path latency is 0 cycles (combinational). `din_ready` → `s_ready` is combinational; `udp_tx_path` must not form a loop through it.
- `trunc_err` is registered and asserts the cycle after the truncating word is accepted.
- A source dropping `s_valid` mid-packet keeps the grant; there is no timeout.

## Structure
- All state is flat in one module of roughly 250 lines.
- A shared package `udp_pkg` holds the state encoding (IDLE=0, PASS=1, DRAIN=2) and `DATA_W`.
- One natural sub-module, `rr_pick`: a combinational round-robin priority picker with inputs `req[NUM_SRC]` and `last[$clog2(NUM_SRC)]`, and outputs `gnt_idx` and `any`.

## Test plan
1. **Interleaved sources.** Sources 0 and 2 each hold a 2-word packet; `cfg_rate`=0. Required: source 0's packet (`grant_id`=0), one idle cycle, then source 2's packet; `din_last` on words 2 and 4.
2. **Fairness.** All 4 sources request continuously with 1-word packets. Required: grant order 0,1,2,3,0,1,… with no source repeated before the others are served.
3. **Rate limit.** `PERIOD_CYC`=100, `cfg_rate`=2, source 1 always requesting. Required: exactly 2 packets per 100-cycle window; the third is granted only after the wrap.
4. **Truncation.** `MAX_WORDS`=4; source 3 sends 6 words with `s_last` on word 6. Required: `din_last` forced on word 4, `trunc_err` pulses once, words 5–6 are consumed with `din_valid`=0, then IDLE.
5. **Backpressure.** Random `din_ready` (about 1/3 low) during a 3-word packet. Required: no word lost or duplicated; `s_ready[grant]` mirrors `din_ready` each cycle.
6. **Reset mid-packet.** Assert `sys_rst_n` low while in PASS. Required: outputs go to their reset values immediately, and the next grant goes to source 0.
